// File: rtl/hit_judge_if.sv
// Signal bundle between the game controller, object mover and player logic
// and the hit judge.
interface hit_judge_if;
  logic        start;
  logic [11:0] obj_x;
  logic [11:0] obj_y;
  logic        obj_wrap;
  logic        end_show;
  logic [11:0] ply_x;
  logic [11:0] ply_y;
  logic        freeze;
  logic        hit;
  logic [7:0]  score;
  logic [2:0]  lives;
  logic        game_over;
  logic        win;
  logic [1:0]  state;

  modport master (
    output start, obj_x, obj_y, obj_wrap, end_show, ply_x, ply_y,
    input  freeze, hit, score, lives, game_over, win, state
  );

  modport slave (
    input  start, obj_x, obj_y, obj_wrap, end_show, ply_x, ply_y,
    output freeze, hit, score, lives, game_over, win, state
  );
endinterface

// File: rtl/hit_judge.sv
// Collision judge for the falling-object game: detects object/player overlap,
// keeps score and lives, and freezes the object mover after each hit.
module hit_judge #(
  parameter int unsigned OBJ_W      = 40,
  parameter int unsigned OBJ_H      = 40,
  parameter int unsigned PLY_W      = 60,
  parameter int unsigned PLY_H      = 60,
  parameter int unsigned LIVES0     = 3,
  parameter int unsigned FREEZE_CYC = 30
) (
  input  logic        clk_cnt,
  input  logic        rst,
  hit_judge_if.slave  bus
);

  localparam int unsigned CNT_W = (FREEZE_CYC > 1) ? $clog2(FREEZE_CYC) : 1;
  localparam logic [2:0]       LIVES_INIT = 3'(LIVES0);
  localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'(FREEZE_CYC - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    HIT  = 2'd2,
    OVER = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       score_q, score_d;
  logic [2:0]       lives_q, lives_d;
  logic             hit_q, hit_d;
  logic             game_over_q, game_over_d;
  logic             win_q, win_d;
  logic             freeze_q, freeze_d;
  logic             armed_q, armed_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Widen to 13 bits so box edges near 4095 do not wrap back to zero
  logic [12:0] ox_c, oy_c, px_c, py_c;
  logic        overlap_c;

  assign ox_c = 13'(bus.obj_x);
  assign oy_c = 13'(bus.obj_y);
  assign px_c = 13'(bus.ply_x);
  assign py_c = 13'(bus.ply_y);

  assign overlap_c = (ox_c < px_c + 13'(PLY_W)) && (px_c < ox_c + 13'(OBJ_W)) &&
                     (oy_c < py_c + 13'(PLY_H)) && (py_c < oy_c + 13'(OBJ_H));

  // State register and all registered outputs
  always_ff @(posedge clk_cnt or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      score_q     <= 8'd0;
      lives_q     <= LIVES_INIT;
      hit_q       <= 1'b0;
      game_over_q <= 1'b0;
      win_q       <= 1'b0;
      freeze_q    <= 1'b1;
      armed_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      score_q     <= score_d;
      lives_q     <= lives_d;
      hit_q       <= hit_d;
      game_over_q <= game_over_d;
      win_q       <= win_d;
      freeze_q    <= freeze_d;
      armed_q     <= armed_d;
      cnt_q       <= cnt_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    score_d = score_q;
    lives_d = lives_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    hit_d   = 1'b0;
    // A new object pass re-arms unless this very cycle registers a hit
    armed_d = armed_q | bus.obj_wrap;

    case (state_q)
      IDLE, OVER: begin
        if (bus.start) begin
          state_d = PLAY;
          score_d = 8'd0;
          lives_d = LIVES_INIT;
          win_d   = 1'b0;
          armed_d = 1'b1;
        end
      end
      PLAY: begin
        if (bus.end_show) begin
          state_d = OVER;
          win_d   = 1'b1;
        end else if (overlap_c && armed_q) begin
          state_d = HIT;
          hit_d   = 1'b1;
          lives_d = (lives_q != 3'd0) ? lives_q - 3'd1 : 3'd0;
          armed_d = 1'b0;
          cnt_d   = CNT_LOAD;
        end else if (bus.obj_wrap && armed_q && (score_q != 8'hFF)) begin
          score_d = score_q + 8'd1;
        end
      end
      HIT: begin
        if (lives_q == 3'd0) begin
          state_d = OVER;
          win_d   = 1'b0;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = PLAY;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    freeze_d    = (state_d != PLAY);
    game_over_d = (state_d == OVER);
  end

  assign bus.freeze    = freeze_q;
  assign bus.hit       = hit_q;
  assign bus.score     = score_q;
  assign bus.lives     = lives_q;
  assign bus.game_over = game_over_q;
  assign bus.win       = win_q;
  assign bus.state     = state_q;

endmodule
